// File: rtl/gray_frame_streamer.sv
// Streams a grayscale frame from a registered-read RAM as valid/ready bytes, raster order from address 0.
// Reads are throttled so in-flight reads plus buffered pixels never exceed a 2-entry FIFO.
//
// state  | meaning
// IDLE   | waiting for io_start
// STREAM | issuing reads, emitting beats
// DRAIN  | all reads issued, emptying pipeline
// DONE   | one-cycle io_done pulse
module gray_frame_streamer #(
    parameter int ADDR_WIDTH  = 18,
    parameter int DATA_WIDTH  = 8,
    parameter int PIXEL_COUNT = 262144
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_start,
    output logic                  io_busy,
    output logic                  io_done,
    output logic [ADDR_WIDTH-1:0] io_ram_addr,
    input  logic [DATA_WIDTH-1:0] io_ram_data,
    output logic                  io_out_valid,
    input  logic                  io_out_ready,
    output logic [DATA_WIDTH-1:0] io_out_data,
    output logic                  io_out_last
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

    // One extra bit so a full 2^ADDR_WIDTH frame compares correctly.
    localparam logic [ADDR_WIDTH:0] LP_LAST = (ADDR_WIDTH+1)'(PIXEL_COUNT - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH:0]   r_issue_cnt;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic [1:0]            r_fifo_last;
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_fifo_cnt;

    logic [1:0]            w_occ;
    logic                  w_fire;
    logic                  w_issue;
    logic                  w_issue_last;

    assign io_out_valid = (r_fifo_cnt != 2'd0);
    assign io_out_data  = r_fifo_data[r_rd_ptr];
    assign io_out_last  = io_out_valid & r_fifo_last[r_rd_ptr];
    assign io_ram_addr  = r_issue_cnt[ADDR_WIDTH-1:0];

    assign w_fire       = io_out_valid & io_out_ready;
    assign w_occ        = r_fifo_cnt + 2'(r_inflight);
    assign w_issue      = (r_state == S_STREAM) &&
                          ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_fire));
    assign w_issue_last = w_issue && (r_issue_cnt == LP_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (io_start) w_next_state = S_STREAM;
            S_STREAM: if (w_issue_last) w_next_state = S_DRAIN;
            S_DRAIN:  if (w_fire && io_out_last) w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        io_busy = 1'b0;
        io_done = 1'b0;
        case (r_state)
            S_STREAM: io_busy = 1'b1;
            S_DRAIN:  io_busy = 1'b1;
            S_DONE:   io_done = 1'b1;
            default:  ;
        endcase
    end

    // Address holds at the last pixel once issued; cleared on the way back to idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_issue_cnt     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (r_state == S_DONE) begin
                r_issue_cnt <= '0;
            end else if (w_issue && !w_issue_last) begin
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
            r_fifo_last <= '0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_fifo_cnt  <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= io_ram_data;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_fire) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({r_inflight, w_fire})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

endmodule

// File: doc/gray_frame_streamer.md
Name: gray_frame_streamer

Overview:
- Reads the processed grayscale frame out of ProcessMain's output RAM and transmits it as a valid/ready byte stream, in raster order from address 0.
- Drives the same address/data read port the bench uses for dumping: address out, 8-bit data in, one-cycle registered read latency.
- Lets hardware (UART/DMA/display path) consume io_convert_done results without a bench-side dump loop.

Parameters:
- ADDR_WIDTH, 18, width of RAM address port
- DATA_WIDTH, 8, gray pixel width
- PIXEL_COUNT, 262144, pixels per frame (512x512); must be >=1 and <= 2^ADDR_WIDTH

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- io_start  in  1  start one frame transfer; sampled only in IDLE
- io_busy  out  1  high from the cycle after start is accepted until io_done
- io_done  out  1  single-cycle pulse after the final beat handshake
- io_ram_addr  out  ADDR_WIDTH  read address to output RAM (registered)
- io_ram_data  in  DATA_WIDTH  RAM read data, valid the cycle after the address
- io_out_valid  out  1  stream beat valid
- io_out_ready  in  1  downstream accept
- io_out_data  out  DATA_WIDTH  gray pixel
- io_out_last  out  1  high on the beat for address PIXEL_COUNT-1

Behaviour:
- Reset values: io_busy=0, io_done=0, io_ram_addr=0, io_out_valid=0, io_out_data=0, io_out_last=0; state=IDLE, FIFO empty, counters 0.
- States:
  - IDLE: io_start=1 -> STREAM.
  - STREAM: all PIXEL_COUNT reads issued -> DRAIN.
  - DRAIN: final beat accepted -> DONE.
  - DONE: lasts one cycle with io_done=1 -> IDLE.
- Start handling: io_start is ignored outside IDLE. A level-held io_start restarts the frame after DONE.
- Read issue: in STREAM, a read is issued by presenting the issue counter on io_ram_addr. The counter increments on each issue and holds at PIXEL_COUNT-1 after the last issue.
- Read latency: data from an issue in cycle t is captured from io_ram_data at the end of cycle t+1 into a 2-entry FIFO.
- Occupancy: occ = FIFO entries + reads in flight, max 2.
  - A read may issue when occ<2, or when occ==2 and a beat fires in the same cycle.
  - Guarantees no overflow and sustains 1 beat/cycle under continuous ready.
- Stream output: io_out_valid = FIFO non-empty, with io_out_data/io_out_last taken from the FIFO head.
  - Fire = io_out_valid & io_out_ready.
  - While io_out_valid=1 and io_out_ready=0, io_out_data and io_out_last stay stable, and io_out_valid does not drop.
- Timing: if start is sampled at edge E0, address 0 is presented in cycle 1 and the first io_out_valid occurs in cycle 3.
- io_out_last is high only for the beat carrying address PIXEL_COUNT-1, so exactly PIXEL_COUNT beats are emitted, in address order, with no duplicates.
- io_done asserts the cycle after the last fire, and io_busy falls in that same cycle.
- Counters are ADDR_WIDTH+1 bits wide so PIXEL_COUNT=2^ADDR_WIDTH does not wrap early.
- Reset mid-frame: all state returns to reset values on the next edge, in-flight data is discarded, io_out_valid=0, and no io_done is generated.

Test Plan:
- PIXEL_COUNT=16, RAM model data=(addr*3)&0xFF, io_out_ready=1, start pulse at E0:
  - required: io_out_valid first high in cycle 3, then 16 consecutive beats 0x00,0x03,...,0x2D;
  - io_out_last only on 0x2D;
  - io_done pulses once the following cycle.
- PIXEL_COUNT=16, io_out_ready held 0 for 10 cycles after start:
  - required: exactly addresses 0 and 1 issued, io_ram_addr frozen at 2, io_out_data=0x00 stable;
  - after ready=1, all 16 beats arrive in order with no loss.
- PIXEL_COUNT=16, random io_out_ready (50%):
  - required: received sequence equals (i*3)&0xFF for i=0..15, exactly one io_out_last, data stable while stalled.
- PIXEL_COUNT=16, io_start re-pulsed during beat 4:
  - required: ignored, 16 beats total, single io_done.
- PIXEL_COUNT=16, reset asserted after beat 5 is accepted:
  - required: io_out_valid=0 and io_busy=0 the next cycle, no io_done;
  - a new start then streams from 0x00.
- Default parameters connected to ProcessMain after io_convert_done, with the lena_bgr.hex load:
  - required: 262144 beats byte-identical to the per-address dump into output_gray.hex.
